// File: rtl/ctrl_decode_pipe_if.sv
// ID-side decode/issue bundle for ctrl_decode_pipe: instruction fields and
// hazard inputs in, D-stage and ID/EX control outputs back.
interface ctrl_decode_pipe_if #(
  parameter int ALU_CTRL_W = 4
);
  logic                  instr_valid_i;
  logic [5:0]            op_i;
  logic [5:0]            funct_i;
  logic                  stall_i;
  logic                  flush_i;

  logic                  branch_d;
  logic                  bne_d;
  logic                  jump_d;
  logic                  jr_d;
  logic                  illegal_d;
  logic                  stall_o;
  logic                  muldiv_busy_o;

  logic                  reg_write_e;
  logic                  mem_to_reg_e;
  logic                  mem_write_e;
  logic                  alu_src_e;
  logic                  zero_ext_e;
  logic                  link_e;
  logic                  illegal_e;
  logic [ALU_CTRL_W-1:0] alu_ctrl_e;
  logic [1:0]            reg_dst_e;
  logic [1:0]            hilo_rd_e;
  logic                  muldiv_start_e;
  logic [1:0]            muldiv_op_e;

  modport master (
    output instr_valid_i, op_i, funct_i, stall_i, flush_i,
    input  branch_d, bne_d, jump_d, jr_d, illegal_d, stall_o, muldiv_busy_o,
    input  reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, zero_ext_e,
    input  link_e, illegal_e, alu_ctrl_e, reg_dst_e, hilo_rd_e,
    input  muldiv_start_e, muldiv_op_e
  );

  modport slave (
    input  instr_valid_i, op_i, funct_i, stall_i, flush_i,
    output branch_d, bne_d, jump_d, jr_d, illegal_d, stall_o, muldiv_busy_o,
    output reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, zero_ext_e,
    output link_e, illegal_e, alu_ctrl_e, reg_dst_e, hilo_rd_e,
    output muldiv_start_e, muldiv_op_e
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// MIPS ID-stage decoder: combinational branch/jump controls, registered ID/EX
// control bundle, and a mult/div busy sequencer that stalls HI/LO dependents.
module ctrl_decode_pipe #(
  parameter int ALU_CTRL_W = 4,
  parameter int MULDIV_LAT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ctrl_decode_pipe_if.slave bus
);

  localparam int CW = $clog2(MULDIV_LAT + 1);

  typedef struct packed {
    logic                  rw;
    logic                  m2r;
    logic                  mw;
    logic                  asrc;
    logic                  zx;
    logic                  lnk;
    logic                  ill;
    logic [ALU_CTRL_W-1:0] alu;
    logic [1:0]            rdst;
    logic [1:0]            hilo;
    logic                  start;
    logic [1:0]            mop;
  } ctrl_t;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  ctrl_t   w_dec;
  ctrl_t   r_e;
  logic [3:0] w_alu4;
  logic    w_branch, w_bne, w_jump, w_jr, w_ill;
  logic    w_bubble, w_issue_md, w_stall;
  state_t  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  always_comb begin
    w_dec    = '0;
    w_alu4   = '0;
    w_branch = 1'b0;
    w_bne    = 1'b0;
    w_jump   = 1'b0;
    w_jr     = 1'b0;
    w_ill    = 1'b0;
    if (bus.instr_valid_i) begin
      case (bus.op_i)
        6'b000000: begin
          case (bus.funct_i)
            6'b100000, 6'b100001: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b0000; end
            6'b100010, 6'b100011: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b0001; end
            6'b100100: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b0010; end
            6'b100101: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b0011; end
            6'b100110: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b0100; end
            6'b100111: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b0101; end
            6'b101010: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b0110; end
            6'b000100: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b0111; end
            6'b000110: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b1000; end
            6'b000111: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_alu4 = 4'b1001; end
            6'b001000: w_jr = 1'b1;
            6'b010000: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_dec.hilo = 2'b01; end
            6'b010010: begin w_dec.rw = 1'b1; w_dec.rdst = 2'b01; w_dec.hilo = 2'b10; end
            6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
              w_dec.start = 1'b1;
              w_dec.mop   = bus.funct_i[1:0];
            end
            default: w_ill = 1'b1;
          endcase
        end
        6'b001000, 6'b001001: begin w_dec.rw = 1'b1; w_dec.asrc = 1'b1; w_alu4 = 4'b0000; end
        6'b001010: begin w_dec.rw = 1'b1; w_dec.asrc = 1'b1; w_alu4 = 4'b0110; end
        6'b001100: begin w_dec.rw = 1'b1; w_dec.asrc = 1'b1; w_dec.zx = 1'b1; w_alu4 = 4'b0010; end
        6'b001101: begin w_dec.rw = 1'b1; w_dec.asrc = 1'b1; w_dec.zx = 1'b1; w_alu4 = 4'b0011; end
        6'b001110: begin w_dec.rw = 1'b1; w_dec.asrc = 1'b1; w_dec.zx = 1'b1; w_alu4 = 4'b0100; end
        6'b001111: begin w_dec.rw = 1'b1; w_dec.asrc = 1'b1; w_alu4 = 4'b1010; end
        6'b100011: begin w_dec.rw = 1'b1; w_dec.asrc = 1'b1; w_dec.m2r = 1'b1; end
        6'b101011: begin w_dec.asrc = 1'b1; w_dec.mw = 1'b1; end
        6'b000100: begin w_branch = 1'b1; w_alu4 = 4'b0001; end
        6'b000101: begin w_branch = 1'b1; w_bne = 1'b1; w_alu4 = 4'b0001; end
        6'b000010: w_jump = 1'b1;
        6'b000011: begin
          w_jump    = 1'b1;
          w_dec.rw  = 1'b1;
          w_dec.rdst = 2'b10;
          w_dec.lnk = 1'b1;
        end
        default: w_ill = 1'b1;
      endcase
    end
    w_dec.alu = ALU_CTRL_W'(w_alu4);
    w_dec.ill = w_ill;
  end

  // Only HI/LO producers and consumers wait on the sequencer; all else flows.
  assign w_stall    = (r_state == S_BUSY) && (w_dec.start || (w_dec.hilo != 2'b00));
  assign w_bubble   = bus.flush_i || bus.stall_i || w_stall;
  assign w_issue_md = w_dec.start && !w_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
    end else if (w_bubble) begin
      r_e <= '0;
    end else begin
      r_e <= w_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_issue_md) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CW'(MULDIV_LAT);
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.branch_d       = w_branch;
  assign bus.bne_d          = w_bne;
  assign bus.jump_d         = w_jump;
  assign bus.jr_d           = w_jr;
  assign bus.illegal_d      = w_ill;
  assign bus.stall_o        = w_stall;
  assign bus.muldiv_busy_o  = (r_state == S_BUSY);

  assign bus.reg_write_e    = r_e.rw;
  assign bus.mem_to_reg_e   = r_e.m2r;
  assign bus.mem_write_e    = r_e.mw;
  assign bus.alu_src_e      = r_e.asrc;
  assign bus.zero_ext_e     = r_e.zx;
  assign bus.link_e         = r_e.lnk;
  assign bus.illegal_e      = r_e.ill;
  assign bus.alu_ctrl_e     = r_e.alu;
  assign bus.reg_dst_e      = r_e.rdst;
  assign bus.hilo_rd_e      = r_e.hilo;
  assign bus.muldiv_start_e = r_e.start;
  assign bus.muldiv_op_e    = r_e.mop;

endmodule
